// File: rtl/xgmii_pkg.sv
// rtl/xgmii_pkg.sv - XGMII control codes, RX FSM state and saturating arithmetic helpers
package xgmii_pkg;

    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_ERROR = 8'hFE;
    localparam logic [7:0] XGMII_IDLE  = 8'h07;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_IN_FRAME = 1'b1
    } rx_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/xgmii_lane_decode.sv
// rtl/xgmii_lane_decode.sv - combinational decode of one 64-bit XGMII word into start/terminate/error flags
module xgmii_lane_decode (
    input  logic [63:0] d,
    input  logic [7:0]  c,
    output logic        sof,
    output logic        term_hit,
    output logic [2:0]  term_lane,
    output logic        ctrl_any,
    output logic        err_any
);
    import xgmii_pkg::*;

    always_comb begin
        sof       = c[0] && (d[7:0] == XGMII_START);
        ctrl_any  = |c;
        term_hit  = 1'b0;
        term_lane = 3'd0;
        err_any   = 1'b0;
        // Descending scan so the lowest terminating lane is the one that sticks.
        for (int k = 7; k >= 0; k--) begin
            if (c[k] && (d[8*k +: 8] == XGMII_TERM)) begin
                term_hit  = 1'b1;
                term_lane = 3'(k);
            end
            if (c[k] && (d[8*k +: 8] == XGMII_ERROR)) begin
                err_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xgmii_rx_monitor.sv
// rtl/xgmii_rx_monitor.sv - XGMII RX frame statistics and TX-to-RX SOF round-trip latency monitor
module xgmii_rx_monitor #(
    parameter logic [15:0] MAX_LEN     = 16'd1518,
    parameter logic [15:0] MIN_LEN     = 16'd64,
    parameter logic [15:0] LAT_TIMEOUT = 16'hFFFF
) (
    input  logic        xgemac_clk_156,
    input  logic        sys_rst,
    input  logic [63:0] xgmii_tx_d,
    input  logic [7:0]  xgmii_tx_c,
    input  logic [63:0] xgmii_rx_d,
    input  logic [7:0]  xgmii_rx_c,
    input  logic        stats_clr,
    output logic        in_frame,
    output logic        frame_done,
    output logic [15:0] rx_last_len,
    output logic [31:0] rx_frame_cnt,
    output logic [31:0] rx_byte_cnt,
    output logic [15:0] rx_err_cnt,
    output logic [15:0] rx_runt_cnt,
    output logic        lat_valid,
    output logic [15:0] lat_last,
    output logic [15:0] lat_min,
    output logic [15:0] lat_max,
    output logic [15:0] lat_lost_cnt
);
    import xgmii_pkg::*;

    logic       tx_sof;
    logic       tx_term_unused, tx_ctrl_unused, tx_err_unused;
    logic [2:0] tx_lane_unused;
    logic       rx_sof, rx_term_hit, rx_ctrl_any, rx_err_any;
    logic [2:0] rx_term_lane;

    xgmii_lane_decode u_tx_decode (
        .d         (xgmii_tx_d),
        .c         (xgmii_tx_c),
        .sof       (tx_sof),
        .term_hit  (tx_term_unused),
        .term_lane (tx_lane_unused),
        .ctrl_any  (tx_ctrl_unused),
        .err_any   (tx_err_unused)
    );

    xgmii_lane_decode u_rx_decode (
        .d         (xgmii_rx_d),
        .c         (xgmii_rx_c),
        .sof       (rx_sof),
        .term_hit  (rx_term_hit),
        .term_lane (rx_term_lane),
        .ctrl_any  (rx_ctrl_any),
        .err_any   (rx_err_any)
    );

    rx_state_t   state;
    logic [15:0] len;
    logic        bad;
    logic [3:0]  term_bytes;
    logic [16:0] len_sum;
    logic [15:0] len_next;
    logic        bad_next;
    logic        ev_close, ev_good, ev_err;
    logic [15:0] close_len;

    always_comb begin
        term_bytes = 4'd0;
        for (int k = 0; k < 8; k++) begin
            if ((k < int'(rx_term_lane)) && !xgmii_rx_c[k]) begin
                term_bytes = term_bytes + 4'd1;
            end
        end
        len_sum  = {1'b0, len} + (rx_term_hit ? {13'd0, term_bytes} : 17'd8);
        len_next = len_sum[16] ? 16'hFFFF : len_sum[15:0];
        bad_next = bad | rx_err_any | (len_next > MAX_LEN);
    end

    // Frame-closing events; a restart SOF or stray control word closes as an error.
    always_comb begin
        ev_close  = 1'b0;
        ev_good   = 1'b0;
        close_len = len;
        if (state == ST_IN_FRAME) begin
            if (rx_sof) begin
                ev_close = 1'b1;
            end else if (rx_term_hit) begin
                ev_close  = 1'b1;
                ev_good   = ~bad_next;
                close_len = len_next;
            end else if (rx_ctrl_any) begin
                ev_close = 1'b1;
            end
        end
        ev_err = ev_close & ~ev_good;
    end

    always_ff @(posedge xgemac_clk_156) begin
        if (sys_rst) begin
            state       <= ST_IDLE;
            in_frame    <= 1'b0;
            len         <= 16'd0;
            bad         <= 1'b0;
            frame_done  <= 1'b0;
            rx_last_len <= 16'd0;
        end else begin
            frame_done <= ev_close;
            if (ev_close) begin
                rx_last_len <= close_len;
            end
            case (state)
                ST_IDLE: begin
                    if (rx_sof) begin
                        state    <= ST_IN_FRAME;
                        in_frame <= 1'b1;
                        len      <= 16'd0;
                        bad      <= 1'b0;
                    end
                end
                ST_IN_FRAME: begin
                    if (rx_sof) begin
                        len <= 16'd0;
                        bad <= 1'b0;
                    end else if (rx_term_hit || rx_ctrl_any) begin
                        state    <= ST_IDLE;
                        in_frame <= 1'b0;
                    end else begin
                        len <= len_next;
                        bad <= bad_next;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    in_frame <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge xgemac_clk_156) begin
        if (sys_rst || stats_clr) begin
            rx_frame_cnt <= 32'd0;
            rx_byte_cnt  <= 32'd0;
            rx_err_cnt   <= 16'd0;
            rx_runt_cnt  <= 16'd0;
        end else begin
            if (ev_good) begin
                rx_frame_cnt <= sat_inc32(rx_frame_cnt);
                rx_byte_cnt  <= sat_add32(rx_byte_cnt, {16'd0, close_len});
                if (close_len < MIN_LEN) begin
                    rx_runt_cnt <= sat_inc16(rx_runt_cnt);
                end
            end
            if (ev_err) begin
                rx_err_cnt <= sat_inc16(rx_err_cnt);
            end
        end
    end

    logic [15:0] now, ts, age, lat_delta;
    logic        pending, sample_hit, capture, timeout;

    assign sample_hit = rx_sof & pending;
    assign capture    = tx_sof & (~pending | sample_hit);
    assign timeout    = pending & ~sample_hit & (age == LAT_TIMEOUT);
    assign lat_delta  = now - ts;

    // Timestamp tracking is untouched by stats_clr so an in-flight measurement survives a clear.
    always_ff @(posedge xgemac_clk_156) begin
        if (sys_rst) begin
            now       <= 16'd0;
            ts        <= 16'd0;
            age       <= 16'd0;
            pending   <= 1'b0;
            lat_valid <= 1'b0;
        end else begin
            now       <= now + 16'd1;
            lat_valid <= sample_hit;
            if (capture) begin
                ts      <= now;
                pending <= 1'b1;
                age     <= 16'd0;
            end else if (sample_hit || timeout) begin
                pending <= 1'b0;
                age     <= 16'd0;
            end else if (pending) begin
                age <= age + 16'd1;
            end
        end
    end

    always_ff @(posedge xgemac_clk_156) begin
        if (sys_rst || stats_clr) begin
            lat_last     <= 16'd0;
            lat_min      <= 16'hFFFF;
            lat_max      <= 16'd0;
            lat_lost_cnt <= 16'd0;
        end else begin
            if (sample_hit) begin
                lat_last <= lat_delta;
                if (lat_delta < lat_min) begin
                    lat_min <= lat_delta;
                end
                if (lat_delta > lat_max) begin
                    lat_max <= lat_delta;
                end
            end
            if (timeout) begin
                lat_lost_cnt <= sat_inc16(lat_lost_cnt);
            end
        end
    end

endmodule
